// File: rtl/hdc_hamming_classifier.sv
// Streams one binarized hypervector word per cycle, accumulates the Hamming distance
// to the stored ham and spam class vectors, and reports the nearer class.
module hdc_hamming_classifier #(
    parameter int DIM    = 10000,
    parameter int WORD_W = 32,
    parameter int NWORDS = (DIM + WORD_W - 1) / WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ref_we,
    input  logic              ref_sel,
    input  logic [8:0]        ref_addr,
    input  logic [WORD_W-1:0] ref_data,
    input  logic              hv_valid,
    output logic              hv_ready,
    input  logic [WORD_W-1:0] hv_data,
    input  logic              hv_last,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [1:0]        result,
    output logic [15:0]       count_ham,
    output logic [15:0]       count_spam,
    output logic              err
);

    localparam int         LAST_BITS = DIM - (NWORDS - 1) * WORD_W;
    localparam logic [8:0] LAST_IDX  = 9'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DONE} state_t;

    state_t      state_q, state_d;
    logic [8:0]  widx_q, widx_d;
    logic [15:0] count_ham_q, count_ham_d;
    logic [15:0] count_spam_q, count_spam_d;
    logic [1:0]  result_q, result_d;
    logic        err_q, err_d;

    logic [WORD_W-1:0] ham_mem  [NWORDS];
    logic [WORD_W-1:0] spam_mem [NWORDS];

    logic [8:0]        cur_idx;
    logic [WORD_W-1:0] mask;
    logic [15:0]       pop_ham, pop_spam;
    logic              beat, frame_end, frame_err;

    // Only the valid dimensions of the final word take part in the distance.
    function automatic logic [WORD_W-1:0] word_mask(input logic [8:0] idx);
        logic [WORD_W-1:0] m;
        m = '1;
        if (idx == LAST_IDX) begin
            for (int j = 0; j < WORD_W; j++) begin
                m[j] = (j < LAST_BITS);
            end
        end
        return m;
    endfunction

    function automatic logic [15:0] popcount(input logic [WORD_W-1:0] v);
        logic [15:0] c;
        c = '0;
        for (int j = 0; j < WORD_W; j++) begin
            c = c + 16'(v[j]);
        end
        return c;
    endfunction

    // A beat in IDLE always starts a fresh frame at word 0, whatever widx was left at.
    assign cur_idx   = (state_q == IDLE) ? 9'd0 : widx_q;
    assign mask      = word_mask(cur_idx);
    assign pop_ham   = popcount((hv_data ^ ham_mem[cur_idx]) & mask);
    assign pop_spam  = popcount((hv_data ^ spam_mem[cur_idx]) & mask);

    assign hv_ready  = !reset && (((state_q == IDLE) && !ref_we) || (state_q == ACCUM));
    assign beat      = hv_valid && hv_ready;
    assign frame_end = hv_last || (cur_idx == LAST_IDX);
    assign frame_err = (hv_last && (cur_idx != LAST_IDX)) || ((cur_idx == LAST_IDX) && !hv_last);

    always_ff @(posedge clk) begin
        if (!reset && (state_q == IDLE) && ref_we && (ref_addr <= LAST_IDX)) begin
            if (ref_sel) begin
                ham_mem[ref_addr] <= ref_data;
            end else begin
                spam_mem[ref_addr] <= ref_data;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        count_ham_d  = count_ham_q;
        count_spam_d = count_spam_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    if (state_q == IDLE) begin
                        count_ham_d  = pop_ham;
                        count_spam_d = pop_spam;
                        err_d        = 1'b0;
                    end else begin
                        count_ham_d  = count_ham_q + pop_ham;
                        count_spam_d = count_spam_q + pop_spam;
                    end
                    widx_d = cur_idx + 9'd1;
                    if (frame_end) begin
                        err_d   = frame_err;
                        state_d = DECIDE;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DECIDE: begin
                if (count_ham_q < count_spam_q) begin
                    result_d = 2'b01;
                end else if (count_ham_q > count_spam_q) begin
                    result_d = 2'b00;
                end else begin
                    result_d = 2'b11;
                end
                state_d = DONE;
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            widx_q       <= '0;
            count_ham_q  <= '0;
            count_spam_q <= '0;
            result_q     <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            count_ham_q  <= count_ham_d;
            count_spam_q <= count_spam_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign result_valid = (state_q == DONE);
    assign result       = result_q;
    assign count_ham    = count_ham_q;
    assign count_spam   = count_spam_q;
    assign err          = err_q;

endmodule

// File: tb/tb_hdc_hamming_classifier.sv
// Directed bench for hdc_hamming_classifier with a reference model and result scoreboard.
module tb_hdc_hamming_classifier;

    localparam int NW = 313;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ref_we = 1'b0;
    logic        ref_sel = 1'b0;
    logic [8:0]  ref_addr = '0;
    logic [31:0] ref_data = '0;
    logic        hv_valid = 1'b0;
    logic        hv_ready;
    logic [31:0] hv_data = '0;
    logic        hv_last = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [1:0]  result;
    logic [15:0] count_ham;
    logic [15:0] count_spam;
    logic        err;

    hdc_hamming_classifier dut (
        .clk          (clk),
        .reset        (reset),
        .ref_we       (ref_we),
        .ref_sel      (ref_sel),
        .ref_addr     (ref_addr),
        .ref_data     (ref_data),
        .hv_valid     (hv_valid),
        .hv_ready     (hv_ready),
        .hv_data      (hv_data),
        .hv_last      (hv_last),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .count_ham    (count_ham),
        .count_spam   (count_spam),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_ham  [NW];
    logic [31:0] m_spam [NW];
    logic [31:0] fbuf   [NW];

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] s;
        logic [1:0]  r;
        logic        e;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: every word = val; mode 1: random words
    task automatic load_ref(input logic sel, input int mode, input logic [31:0] val);
        for (int a = 0; a < NW; a++) begin
            logic [31:0] d;
            d = (mode == 0) ? val : $urandom;
            ref_we = 1'b1; ref_sel = sel; ref_addr = 9'(a); ref_data = d;
            if (sel) m_ham[a] = d; else m_spam[a] = d;
            @(posedge clk); @(negedge clk);
        end
        ref_we = 1'b1; ref_sel = sel; ref_addr = 9'd313; ref_data = $urandom;
        @(posedge clk); @(negedge clk);
        ref_we = 1'b0;
    endtask

    function automatic void push_expected(input int nf, input int last_at);
        int h, s;
        logic [31:0] mk;
        exp_t e;
        h = 0; s = 0;
        for (int w = 0; w < nf; w++) begin
            mk = (w == NW - 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
            h += $countones((fbuf[w] ^ m_ham[w]) & mk);
            s += $countones((fbuf[w] ^ m_spam[w]) & mk);
        end
        e.h = 16'(h);
        e.s = 16'(s);
        e.r = (h < s) ? 2'b01 : ((h > s) ? 2'b00 : 2'b11);
        e.e = ((last_at == nf - 1) && (nf - 1 != NW - 1)) || ((nf - 1 == NW - 1) && (last_at != NW - 1));
        sb.push_back(e);
    endfunction

    task automatic drive_words(input int n, input int last_at, input int stall_at, input bit ends);
        bit rdy_ok;
        rdy_ok = 1'b1;
        for (int w = 0; w < n; w++) begin
            if (w == stall_at) begin
                hv_valid = 1'b0;
                repeat (4) @(negedge clk);
            end
            hv_valid = 1'b1; hv_data = fbuf[w]; hv_last = (w == last_at);
            #1;
            if (hv_ready !== 1'b1) rdy_ok = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        hv_valid = 1'b0; hv_last = 1'b0;
        check("hv_ready_in_frame", 32'(rdy_ok), 32'd1);
        if (ends) begin
            check("latency_edge1_valid", 32'(result_valid), 32'd0);
            check("decide_hv_ready", 32'(hv_ready), 32'd0);
            @(negedge clk);
            check("latency_edge2_valid", 32'(result_valid), 32'd1);
        end
    endtask

    task automatic wait_result();
        int cyc;
        exp_t e;
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("result_valid_seen", 32'(result_valid), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("count_ham", 32'(count_ham), 32'(e.h));
            check("count_spam", 32'(count_spam), 32'(e.s));
            check("result", 32'(result), 32'(e.r));
            check("err", 32'(err), 32'(e.e));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("valid_drop_after_ready", 32'(result_valid), 32'd0);
        check("hv_ready_back_idle", 32'(hv_ready), 32'd1);
    endtask

    task automatic run_frame(input int n, input int last_at, input int stall_at);
        push_expected(n, last_at);
        drive_words(n, last_at, stall_at, 1'b1);
        wait_result();
    endtask

    initial begin
        exp_t held;

        // Reset state
        #2 reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_hv_ready", 32'(hv_ready), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_count_ham", 32'(count_ham), 32'd0);
        check("rst_count_spam", 32'(count_spam), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ham all-ones, spam all-zeros; all-ones frame
        load_ref(1'b1, 0, 32'hFFFFFFFF);
        load_ref(1'b0, 0, 32'h00000000);
        for (int w = 0; w < NW; w++) fbuf[w] = 32'hFFFFFFFF;
        run_frame(NW, NW - 1, -1);
        check("allones_ham_const", 32'(m_ham[5] == 32'hFFFFFFFF), 32'd1);

        // all-zero frame, with the unused upper half of the last word set
        for (int w = 0; w < NW; w++) fbuf[w] = 32'h0;
        fbuf[NW - 1] = 32'hFFFF0000;
        run_frame(NW, NW - 1, -1);

        // identical references -> tie, random data including upper bits of last word
        load_ref(1'b1, 0, 32'hA5A5A5A5);
        load_ref(1'b0, 0, 32'hA5A5A5A5);
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        fbuf[NW - 1] = 32'hFFFF0000 | (fbuf[NW - 1] & 32'h0000FFFF);
        run_frame(NW, NW - 1, -1);

        // random references: short frame, missing hv_last with a stall, then a good frame
        load_ref(1'b1, 1, 32'h0);
        load_ref(1'b0, 1, 32'h0);
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        run_frame(100, 99, -1);
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        run_frame(NW, -1, 50);
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        run_frame(NW, NW - 1, 120);

        // reset after word 150 discards the partial frame
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        drive_words(151, -1, -1, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_count_ham", 32'(count_ham), 32'd0);
        check("midrst_count_spam", 32'(count_spam), 32'd0);
        check("midrst_hv_ready", 32'(hv_ready), 32'd0);
        check("midrst_result_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        run_frame(NW, NW - 1, -1);

        // DONE held for 10 cycles while writes and beats are attempted
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        push_expected(NW, NW - 1);
        drive_words(NW, NW - 1, -1, 1'b1);
        held = sb[0];
        for (int i = 0; i < 10; i++) begin
            ref_we = 1'b1; ref_sel = i[0]; ref_addr = (i < 5) ? 9'd0 : 9'd312;
            ref_data = ~m_ham[0];
            hv_valid = 1'b1; hv_data = $urandom; hv_last = 1'b1;
            #1;
            check("hold_hv_ready", 32'(hv_ready), 32'd0);
            @(negedge clk);
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_count_ham", 32'(count_ham), 32'(held.h));
            check("hold_count_spam", 32'(count_spam), 32'(held.s));
            check("hold_result", 32'(result), 32'(held.r));
            check("hold_err", 32'(err), 32'(held.e));
        end
        ref_we = 1'b0; hv_valid = 1'b0; hv_last = 1'b0;
        wait_result();

        // references must be untouched by the ignored writes
        for (int w = 0; w < NW; w++) fbuf[w] = $urandom;
        run_frame(NW, NW - 1, -1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdc_hamming_classifier.md
HDC_HAMMING_CLASSIFIER -- requirements
Module: hdc_hamming_classifier

Interface
REQ-001: Parameter DIM, default 10000, is the hypervector dimension in bits.
REQ-002: Parameter WORD_W, default 32, is the stream word width in bits.
REQ-003: Parameter NWORDS, default ceil(DIM/WORD_W) = 313, is the number of words per hypervector.
REQ-004: Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005: Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006: Port ref_we, input, 1 bit: reference-memory write strobe.
REQ-007: Port ref_sel, input, 1 bit: selects the target class (0 = spam, 1 = ham).
REQ-008: Port ref_addr, input, 9 bits: reference word index (0..NWORDS-1).
REQ-009: Port ref_data, input, WORD_W bits: reference word data.
REQ-010: Port hv_valid, input, 1 bit: a message-hypervector word is present.
REQ-011: Port hv_ready, output, 1 bit: the block accepts hv_data this cycle.
REQ-012: Port hv_data, input, WORD_W bits: binarized message-hypervector word, bit j of word w = dimension w*WORD_W+j.
REQ-013: Port hv_last, input, 1 bit: marks the final word of a hypervector.
REQ-014: Port result_valid, output, 1 bit: result, count_ham, count_spam and err are valid.
REQ-015: Port result_ready, input, 1 bit: the consumer takes the result.
REQ-016: Port result, output, 2 bits: 2'b00 = spam, 2'b01 = ham, 2'b11 = tie.
REQ-017: Ports count_ham and count_spam, outputs, 16 bits each: Hamming distance to each class vector.
REQ-018: Port err, output, 1 bit: the frame length was not NWORDS words.

Function
REQ-019: Internal storage SHALL hold two arrays of NWORDS x WORD_W bits (ham, spam), with combinational read.
REQ-020: FSM states SHALL be IDLE, ACCUM, DECIDE and DONE.
REQ-021: A reference write SHALL occur only when ref_we=1 in IDLE; ref_we in any other state SHALL be ignored.
REQ-022: A write with ref_addr >= NWORDS SHALL be ignored.
REQ-023: hv_ready SHALL be 1 in IDLE or ACCUM and 0 otherwise, and SHALL also be 0 in an IDLE cycle with ref_we=1, so the reference write has priority.
REQ-024: On a beat (hv_valid & hv_ready), word index widx SHALL be compared against both references.
REQ-025: Each beat SHALL add popcount((hv_data ^ ham[widx]) & mask) to count_ham and popcount((hv_data ^ spam[widx]) & mask) to count_spam, registered at the same edge.
REQ-026: The mask SHALL be all-ones except in word NWORDS-1, where only the low DIM-(NWORDS-1)*WORD_W bits (16 by default) are set.
REQ-027: The first beat in IDLE SHALL clear both counts, the counter and err before accumulating, then move to ACCUM with widx=1.
REQ-028: Each subsequent beat SHALL increment widx.
REQ-029: The frame SHALL end on the beat where hv_last=1 or widx=NWORDS-1, whichever comes first, and the FSM SHALL then move to DECIDE.
REQ-030: err SHALL be set at frame end if (hv_last=1 and widx != NWORDS-1) or (widx=NWORDS-1 and hv_last=0).
REQ-031: In DECIDE, one cycle, result SHALL be registered as 2'b01 if count_ham < count_spam, 2'b00 if count_ham > count_spam, and 2'b11 if they are equal; the FSM then moves to DONE.
REQ-032: In DONE, result_valid SHALL be 1, and all outputs SHALL be held stable until result_ready=1; that cycle returns the FSM to IDLE and result_valid falls on the next edge.
REQ-033: Latency SHALL be 2 clocks: result_valid=1 on the second rising edge after the final beat.
REQ-034: Throughput SHALL be one word per cycle, with a minimum gap of 2 cycles plus the result handshake between frames.
REQ-035: hv_valid low mid-frame SHALL stall without changing state or counts.
REQ-036: Counts SHALL be unsigned 16 bits and cannot overflow (maximum DIM=10000).

Reset
REQ-037: reset=1 SHALL asynchronously force IDLE, widx=0, count_ham=0, count_spam=0, result=2'b00, result_valid=0, err=0.
REQ-038: hv_ready SHALL be 0 while reset=1.
REQ-039: Reference memory contents SHALL NOT be cleared by reset.
REQ-040: A reset mid-frame SHALL discard the partial frame; the next beat after release starts a new frame at widx=0.

Verification
REQ-041: Load ham = all-ones, spam = all-zeros; stream 313 words of 0xFFFFFFFF with hv_last on word 312 -> count_ham=0, count_spam=10000, result=2'b01, err=0, result_valid exactly 2 edges after the last beat.
REQ-042: Same references; stream all-zero words -> count_ham=10000, count_spam=0, result=2'b00.
REQ-043: ham = spam = 0xA5A5A5A5 in every word; stream arbitrary data -> count_ham = count_spam and result=2'b11; check that bits [31:16] of word 312 do not contribute.
REQ-044: Assert hv_last on word 99 -> err=1 and counts cover 100 words; then send 313 words without hv_last -> frame ends at word 312 with err=1.
REQ-045: Assert reset for 1 cycle after word 150, then send a full correct frame -> counts reflect only the new frame, and the reference memory is intact.
REQ-046: Hold result_ready=0 for 10 cycles in DONE, while driving ref_we and hv_valid -> outputs are stable, hv_ready=0, and no reference word changes.
